// File: rtl/alu_pkg.sv
// Shared ALU types: op codes, NZCV flag struct and datapath width.
// Used by the arbiter, decoder and EX stage.
package alu_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester/response/ALU signal bundle of the shared-ALU arbiter.
// slave = arbiter side, master = requesters plus external ALU.
interface alu_share_arbiter_if
  #(parameter int NREQ = 2,
    parameter int W    = alu_pkg::ALU_W);
  import alu_pkg::*;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*3-1:0] req_op;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [W-1:0]      rsp_result;
  alu_flags_t        rsp_flags;
  logic [W-1:0]      alu_a;
  logic [W-1:0]      alu_b;
  alu_op_t           alu_op;
  logic [W-1:0]      alu_result;
  alu_flags_t        alu_flags;
  logic              busy;

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready, alu_result, alu_flags,
    output req_ready, rsp_valid, rsp_result, rsp_flags, alu_a, alu_b, alu_op, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready, alu_result, alu_flags,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, alu_a, alu_b, alu_op, busy
  );

endinterface

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester above ptr_i (wrapping) wins.
// Zero latency; any_o low when nothing requests.
module alu_share_arbiter_rr_pick
  #(parameter int NREQ = 2,
    parameter int PW   = 1)
  (input  logic [NREQ-1:0] req_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [PW-1:0]   idx_o,
   output logic            any_o);

  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Sequences one external ALU among NREQ requesters: grant -> 1 exec cycle -> held response.
// Accept-to-rsp_valid is 2 cycles; response held until the owner's rsp_ready.
module alu_share_arbiter
  import alu_pkg::*;
  #(parameter int NREQ = 2,
    parameter int W    = ALU_W)
  (input logic clk,
   input logic rst_n,
   alu_share_arbiter_if.slave bus);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t     state_q, state_d;
  logic [PW-1:0] rr_q, rr_d, owner_q, owner_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  alu_op_t    op_q, op_d;
  alu_flags_t flg_q, flg_d;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_any;

  alu_share_arbiter_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req_i (bus.req_valid),
    .ptr_i (rr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    owner_d        = owner_q;
    a_d            = a_q;
    b_d            = b_q;
    op_d           = op_q;
    res_d          = res_q;
    flg_d          = flg_q;
    bus.req_ready  = '0;
    bus.rsp_valid  = '0;
    bus.alu_a      = '0;
    bus.alu_b      = '0;
    bus.alu_op     = ALU_ADD;
    bus.busy       = (state_q != S_IDLE);
    bus.rsp_result = res_q;
    bus.rsp_flags  = flg_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          bus.req_ready = gnt;
          rr_d          = gnt_idx;
          owner_d       = gnt_idx;
          a_d           = bus.req_a[int'(gnt_idx)*W +: W];
          b_d           = bus.req_b[int'(gnt_idx)*W +: W];
          op_d          = alu_op_t'(bus.req_op[int'(gnt_idx)*3 +: 3]);
          state_d       = S_EXEC;
        end
      end
      S_EXEC: begin
        bus.alu_a  = a_q;
        bus.alu_b  = b_q;
        bus.alu_op = op_q;
        res_d      = bus.alu_result;
        flg_d      = bus.alu_flags;
        state_d    = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid[owner_q] = 1'b1;
        // Only the owner's acceptance matters; other rsp_ready bits are ignored.
        if (bus.rsp_ready[owner_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= PW'(NREQ - 1);
      owner_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= ALU_ADD;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural 32-bit NZCV ALU on the alu_* side.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 2;
  localparam int W    = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  alu_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [32:0] wide;
  logic [31:0] r;
  logic        c, v;

  always_comb begin
    wide = '0;
    r    = '0;
    c    = 1'b0;
    v    = 1'b0;
    case (bus.alu_op)
      ALU_ADD: begin
        wide = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        r    = wide[31:0];
        c    = wide[32];
        v    = (bus.alu_a[31] == bus.alu_b[31]) && (r[31] != bus.alu_a[31]);
      end
      ALU_SUB: begin
        r = bus.alu_a - bus.alu_b;
        c = (bus.alu_a >= bus.alu_b);
        v = (bus.alu_a[31] != bus.alu_b[31]) && (r[31] != bus.alu_a[31]);
      end
      ALU_AND: r = bus.alu_a & bus.alu_b;
      ALU_OR:  r = bus.alu_a | bus.alu_b;
      ALU_XOR: r = bus.alu_a ^ bus.alu_b;
      ALU_SLT: r = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
      ALU_SLL: r = bus.alu_a << bus.alu_b[4:0];
      ALU_SRL: r = bus.alu_a >> bus.alu_b[4:0];
      default: r = '0;
    endcase
    bus.alu_result = r;
    bus.alu_flags  = {r[31], (r == 32'd0), c, v};
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req_op[i*3 +: 3] = op;
    bus.req_valid[i]    = 1'b1;
  endtask

  // Starts just after a posedge in IDLE; returns at the negedge where rsp_valid[i] is seen (lat=-1 on timeout).
  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       output int lat, output logic [31:0] res, output logic [3:0] fl);
    bit got;
    int k;
    got = 0;
    lat = -1;
    res = '0;
    fl  = '0;
    set_req(i, a, b, op);
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (bus.req_ready[i]) got = 1;
      else begin @(posedge clk); #1; end
    end
    if (!got) return;
    @(posedge clk); #1;
    bus.req_valid[i] = 1'b0;
    k = 1;
    while (lat < 0 && k <= 10) begin
      @(negedge clk);
      if (bus.rsp_valid[i]) begin
        lat = k;
        res = bus.rsp_result;
        fl  = bus.rsp_flags;
      end else begin
        @(posedge clk); #1;
        k++;
      end
    end
  endtask

  task automatic test_reset;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    rst_n         = 1'b0;
    #2;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.busy} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl got ready=%b rsp_valid=%b busy=%b want all 0", bus.req_ready, bus.rsp_valid, bus.busy);
    end
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.rsp_result, bus.rsp_flags} !== '0) begin
      failures++;
      $display("FAIL reset_data got alu_a=%h alu_b=%h op=%b res=%h flags=%b want 0",
               bus.alu_a, bus.alu_b, bus.alu_op, bus.rsp_result, bus.rsp_flags);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.req_ready !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_reset got busy=%b ready=%b want 0/00", bus.busy, bus.req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    bus.rsp_ready = 2'b11;
    set_req(0, 32'd5, 32'd3, ALU_ADD);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b01) begin
      failures++;
      $display("FAIL add_grant got %b want 01", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.rsp_valid !== 2'b00 || bus.alu_a !== 32'd5 || bus.alu_b !== 32'd3 || bus.alu_op !== ALU_ADD) begin
      failures++;
      $display("FAIL add_exec got busy=%b rv=%b a=%0d b=%0d op=%b want 1/00/5/3/000",
               bus.busy, bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_op);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 32'd8 || bus.rsp_flags !== 4'b0000) begin
      failures++;
      $display("FAIL add_resp got rv=%b res=%h flags=%b want 01/8/0000", bus.rsp_valid, bus.rsp_result, bus.rsp_flags);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL add_done got busy=%b rv=%b want 0/00", bus.busy, bus.rsp_valid);
    end
  endtask

  task automatic test_sub;
    int lat;
    logic [31:0] res;
    logic [3:0]  fl;
    bus.rsp_ready = 2'b11;
    issue(1, 32'd3, 32'd5, ALU_SUB, lat, res, fl);
    checks++;
    if (lat != 2 || res !== 32'hFFFF_FFFE || fl !== 4'b1000) begin
      failures++;
      $display("FAIL sub_neg got lat=%0d res=%h flags=%b want 2/fffffffe/1000", lat, res, fl);
    end
    @(posedge clk); #1;
    issue(1, 32'd5, 32'd5, ALU_SUB, lat, res, fl);
    checks++;
    if (lat != 2 || res !== 32'd0 || fl !== 4'b0110) begin
      failures++;
      $display("FAIL sub_zero got lat=%0d res=%h flags=%b want 2/0/0110", lat, res, fl);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin;
    logic [NREQ-1:0] g, want;
    bit got;
    bus.rsp_ready = 2'b11;
    set_req(0, 32'd10, 32'd1, ALU_ADD);
    set_req(1, 32'h0000_00F0, 32'h0000_00FF, ALU_XOR);
    for (int op = 0; op < 6; op++) begin
      want = (op % 2 == 0) ? 2'b01 : 2'b10;
      got  = 0;
      g    = '0;
      for (int t = 0; t < 10 && !got; t++) begin
        @(negedge clk);
        if (bus.req_ready != '0) begin got = 1; g = bus.req_ready; end
        else begin @(posedge clk); #1; end
      end
      checks++;
      if (g !== want) begin
        failures++;
        $display("FAIL rr_order op%0d got grant=%b want %b", op, g, want);
      end
      if (!got) break;
      @(posedge clk); @(posedge clk); @(negedge clk);
      checks++;
      if (bus.rsp_valid !== want || bus.req_ready !== 2'b00 || bus.busy !== 1'b1 ||
          bus.rsp_result !== ((op % 2 == 0) ? 32'd11 : 32'h0000_000F)) begin
        failures++;
        $display("FAIL rr_resp op%0d got rv=%b ready=%b busy=%b res=%h", op, bus.rsp_valid, bus.req_ready, bus.busy, bus.rsp_result);
      end
      @(posedge clk); #1;
    end
    bus.req_valid = '0;
  endtask

  task automatic test_hold_and_nonowner;
    int lat;
    logic [31:0] res;
    logic [3:0]  fl;
    bus.rsp_ready = 2'b00;
    set_req(1, 32'd1, 32'd2, ALU_OR);
    issue(0, 32'd7, 32'd2, ALU_AND, lat, res, fl);
    checks++;
    if (lat != 2 || res !== 32'd2) begin
      failures++;
      $display("FAIL hold_issue got lat=%0d res=%h want 2/2", lat, res);
    end
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 32'd2 || bus.rsp_flags !== 4'b0000 ||
          bus.req_ready !== 2'b00 || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL hold_stable cyc%0d got rv=%b res=%h flags=%b ready=%b busy=%b",
                 n, bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.req_ready, bus.busy);
      end
    end
    bus.rsp_ready = 2'b10;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 2'b01 || bus.busy !== 1'b1 || bus.req_ready !== 2'b00) begin
        failures++;
        $display("FAIL nonowner_ignored cyc%0d got rv=%b busy=%b ready=%b want 01/1/00",
                 n, bus.rsp_valid, bus.busy, bus.req_ready);
      end
    end
    bus.req_valid = '0;
    bus.rsp_ready = 2'b01;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== 2'b00 || bus.rsp_result !== 32'd2 || bus.req_ready !== 2'b00) begin
      failures++;
      $display("FAIL hold_release got busy=%b rv=%b res=%h ready=%b want 0/00/2/00",
               bus.busy, bus.rsp_valid, bus.rsp_result, bus.req_ready);
    end
  endtask

  task automatic test_reset_mid_exec;
    int lat;
    logic [31:0] res;
    logic [3:0]  fl;
    bus.rsp_ready = 2'b11;
    set_req(0, 32'd1, 32'd1, ALU_ADD);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b01) begin
      failures++;
      $display("FAIL mid_grant got %b want 01", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.req_ready, bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_op, bus.rsp_result, bus.rsp_flags} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs got busy=%b rv=%b a=%h res=%h flags=%b want all 0",
               bus.busy, bus.rsp_valid, bus.alu_a, bus.rsp_result, bus.rsp_flags);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL mid_no_rsp cyc%0d got rv=%b busy=%b want 00/0", n, bus.rsp_valid, bus.busy);
      end
    end
    @(posedge clk); #1;
    set_req(0, 32'd4, 32'd4, ALU_ADD);
    set_req(1, 32'd4, 32'd4, ALU_SUB);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b01) begin
      failures++;
      $display("FAIL ptr_restart got %b want 01", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(posedge clk); @(posedge clk); #1;
    issue(1, 32'd9, 32'd4, ALU_SUB, lat, res, fl);
    checks++;
    if (lat != 2 || res !== 32'd5 || fl !== 4'b0010) begin
      failures++;
      $display("FAIL req1_after_reset got lat=%0d res=%h flags=%b want 2/5/0010", lat, res, fl);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_round_robin();
    test_hold_and_nonowner();
    test_reset_mid_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
